burst_instruction_handler: RTL and testbench

BURST_INSTRUCTION_HANDLER -- requirements
Module: burst_instruction_handler

---
 rtl/burst_instruction_handler_if.sv | 27 ++
 rtl/burst_instruction_handler.sv | 222 ++++++++++++++++++++++
 tb/tb_burst_instruction_handler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_instruction_handler_if.sv
// Byte-stream command port and core-side bus of burst_instruction_handler.
// Handshake: one byte transfers on every rising clk edge with spi_rx_valid=1; there is no ready, overflow is reported on error.
interface burst_instruction_handler_if #(
   parameter int ADDR_BYTES = 3,
   parameter int DATA_BYTES = 4
);
   logic                    spi_rx_valid;
   logic [7:0]              spi_rx_byte;
   logic [7:0]              spi_tx_byte;
   logic [7:0]              instruction_bus;
   logic [8*ADDR_BYTES-1:0] address_bus;
   logic [8*DATA_BYTES-1:0] value_bus;
   logic [8*DATA_BYTES-1:0] value_from_core;
   logic                    busy;
   logic                    error;
   logic [2:0]              dbg_state;

   modport slave (
      input  spi_rx_valid, spi_rx_byte, value_from_core,
      output spi_tx_byte, instruction_bus, address_bus, value_bus, busy, error, dbg_state
   );

   modport master (
      output spi_rx_valid, spi_rx_byte, value_from_core,
      input  spi_tx_byte, instruction_bus, address_bus, value_bus, busy, error, dbg_state
   );
endinterface

// File: rtl/burst_instruction_handler.sv
// Decodes an SPI byte stream into WRITE/READ/TRANSFER/BURST_WRITE commands and
// issues one-cycle instruction strobes toward the cores.
module burst_instruction_handler #(
   parameter int ADDR_BYTES     = 3,
   parameter int DATA_BYTES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                        clk,
   input logic                        rst_n,
   burst_instruction_handler_if.slave bus
);
   localparam int AW = 8 * ADDR_BYTES;
   localparam int DW = 8 * DATA_BYTES;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ADDR      = 3'd1;
   localparam logic [2:0] S_COUNT     = 3'd2;
   localparam logic [2:0] S_DATA      = 3'd3;
   localparam logic [2:0] S_ISSUE     = 3'd4;
   localparam logic [2:0] S_READ_WAIT = 3'd5;
   localparam logic [2:0] S_TX        = 3'd6;

   localparam logic [7:0] OP_NOP      = 8'h00;
   localparam logic [7:0] OP_WRITE    = 8'h01;
   localparam logic [7:0] OP_READ     = 8'h02;
   localparam logic [7:0] OP_TRANSFER = 8'h03;
   localparam logic [7:0] OP_BURST    = 8'h04;

   logic [2:0]    state_q, state_d;
   logic [7:0]    op_q, op_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [8:0]    words_q, words_d;
   logic [DW-1:0] rbuf_q, rbuf_d;
   logic [DW-1:0] txsh_q, txsh_d;
   logic [7:0]    tx_q, tx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          skid_v_q, skid_v_d;
   logic [7:0]    skid_b_q, skid_b_d;
   logic          err_q, err_d;

   logic          byte_v;
   logic [7:0]    byte_b;
   logic          issuing;

   assign issuing             = (state_q == S_ISSUE);
   assign bus.instruction_bus = issuing ? ((op_q == OP_READ) ? OP_READ : OP_WRITE) : OP_NOP;
   assign bus.address_bus     = issuing ? addr_q : '0;
   assign bus.value_bus       = (issuing && (op_q != OP_READ)) ? data_q : '0;
   assign bus.spi_tx_byte     = tx_q;
   assign bus.busy            = (state_q != S_IDLE);
   assign bus.error           = err_q;
   assign bus.dbg_state       = state_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      words_d  = words_q;
      rbuf_d   = rbuf_q;
      txsh_d   = txsh_q;
      tx_d     = tx_q;
      tmo_d    = tmo_q;
      skid_v_d = skid_v_q;
      skid_b_d = skid_b_q;
      err_d    = 1'b0;
      byte_v   = 1'b0;
      byte_b   = 8'h00;

      // The skid byte is older than a byte arriving now, so it is consumed
      // first and the new byte takes its place.
      if ((state_q == S_ISSUE) || (state_q == S_READ_WAIT)) begin
         if (bus.spi_rx_valid) begin
            if (skid_v_q) begin
               err_d = 1'b1;
            end else begin
               skid_v_d = 1'b1;
               skid_b_d = bus.spi_rx_byte;
            end
         end
      end else if (skid_v_q) begin
         byte_v   = 1'b1;
         byte_b   = skid_b_q;
         skid_v_d = bus.spi_rx_valid;
         if (bus.spi_rx_valid) skid_b_d = bus.spi_rx_byte;
      end else begin
         byte_v = bus.spi_rx_valid;
         byte_b = bus.spi_rx_byte;
      end

      case (state_q)
         S_IDLE: begin
            if (byte_v) begin
               case (byte_b)
                  OP_WRITE, OP_READ, OP_BURST: begin
                     op_d    = byte_b;
                     cnt_d   = 8'd0;
                     state_d = S_ADDR;
                  end
                  OP_TRANSFER: begin
                     txsh_d  = rbuf_q;
                     cnt_d   = 8'd0;
                     state_d = S_TX;
                  end
                  OP_NOP: ;
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_ADDR: begin
            if (byte_v) begin
               addr_d = AW'({addr_q, byte_b});
               if (cnt_q == 8'(ADDR_BYTES - 1)) begin
                  cnt_d = 8'd0;
                  if (op_q == OP_READ)       state_d = S_ISSUE;
                  else if (op_q == OP_BURST) state_d = S_COUNT;
                  else                       state_d = S_DATA;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_COUNT: begin
            if (byte_v) begin
               words_d = (byte_b == 8'd0) ? 9'd256 : {1'b0, byte_b};
               cnt_d   = 8'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (byte_v) begin
               data_d = DW'({data_q, byte_b});
               if (cnt_q == 8'(DATA_BYTES - 1)) begin
                  cnt_d   = 8'd0;
                  state_d = S_ISSUE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_ISSUE: begin
            if (op_q == OP_READ) begin
               state_d = S_READ_WAIT;
            end else if ((op_q == OP_BURST) && (words_q != 9'd1)) begin
               words_d = words_q - 9'd1;
               addr_d  = addr_q + AW'(1);
               state_d = S_DATA;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ_WAIT: begin
            rbuf_d  = bus.value_from_core;
            state_d = S_IDLE;
         end
         S_TX: begin
            if (byte_v) begin
               tx_d   = txsh_q[DW-1 -: 8];
               txsh_d = txsh_q << 8;
               if (cnt_q == 8'(DATA_BYTES - 1)) begin
                  cnt_d   = 8'd0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // An arriving byte always beats the timeout in the same cycle.
      if (state_q == S_IDLE) begin
         tmo_d = '0;
      end else if (bus.spi_rx_valid) begin
         tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         tmo_d    = '0;
         state_d  = S_IDLE;
         cnt_d    = 8'd0;
         skid_v_d = 1'b0;
         err_d    = 1'b1;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_NOP;
         cnt_q    <= 8'd0;
         addr_q   <= '0;
         data_q   <= '0;
         words_q  <= 9'd0;
         rbuf_q   <= '0;
         txsh_q   <= '0;
         tx_q     <= 8'h00;
         tmo_q    <= '0;
         skid_v_q <= 1'b0;
         skid_b_q <= 8'h00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         words_q  <= words_d;
         rbuf_q   <= rbuf_d;
         txsh_q   <= txsh_d;
         tx_q     <= tx_d;
         tmo_q    <= tmo_d;
         skid_v_q <= skid_v_d;
         skid_b_q <= skid_b_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_burst_instruction_handler.sv
// Self-checking bench for burst_instruction_handler: vector table, strobe
// scoreboard and hand-written multi-cycle corner cases.
module tb_burst_instruction_handler;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   burst_instruction_handler_if #(.ADDR_BYTES(3), .DATA_BYTES(4)) bus ();

   burst_instruction_handler #(
      .ADDR_BYTES(3), .DATA_BYTES(4), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      logic        is_read;
      logic [23:0] addr;
      logic [31:0] val;
      logic [7:0]  exp_instr;
      logic [23:0] exp_addr;
      logic [31:0] exp_val;
      logic [31:0] exp_tx;
   } vec_t;

   vec_t vecs[5];

   int tests_run    = 0;
   int tests_failed = 0;
   int err_seen     = 0;
   int exp_err      = 0;

   // {check_value, instr, addr, value}
   logic [64:0] exp_q[$];
   logic [64:0] sb_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.error) err_seen++;
      if (bus.instruction_bus != 8'h00) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_strobe: got instr %0h addr %0h value %0h expected no strobe",
                     bus.instruction_bus, bus.address_bus, bus.value_bus);
         end else begin
            sb_e = exp_q.pop_front();
            check("strobe",
                  {bus.instruction_bus, bus.address_bus, sb_e[64] ? bus.value_bus : 32'h0},
                  {sb_e[63:32], sb_e[64] ? sb_e[31:0] : 32'h0});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.spi_rx_valid = 1'b1;
      bus.spi_rx_byte  = b;
      @(posedge clk);
      #1;
      bus.spi_rx_valid = 1'b0;
   endtask

   task automatic send_field(input logic [31:0] v, input int nbytes);
      for (int i = nbytes - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
   endtask

   task automatic do_write(input logic [23:0] a, input logic [31:0] v, input int gap);
      send_byte(8'h01);
      send_field({8'h00, a}, 3);
      send_field(v, 4);
      idle(gap);
   endtask

   task automatic do_read(input logic [23:0] a);
      send_byte(8'h02);
      send_field({8'h00, a}, 3);
      idle(2);
   endtask

   task automatic do_transfer(input logic [31:0] exp_tx, input string name);
      send_byte(8'h03);
      for (int i = 3; i >= 0; i--) begin
         send_byte(8'($urandom_range(0, 255)));
         check(name, {56'h0, bus.spi_tx_byte}, {56'h0, exp_tx[8*i +: 8]});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr"}, {56'h0, bus.instruction_bus}, 64'h0);
      check({tag, "_addr"},  {40'h0, bus.address_bus},     64'h0);
      check({tag, "_value"}, {32'h0, bus.value_bus},       64'h0);
      check({tag, "_tx"},    {56'h0, bus.spi_tx_byte},     64'h0);
      check({tag, "_busy"},  {63'h0, bus.busy},            64'h0);
      check({tag, "_error"}, {63'h0, bus.error},           64'h0);
   endtask

   initial begin
      int          err_base;
      logic [23:0] a;
      logic [31:0] v;

      vecs[0] = '{1'b0, 24'h000000, 32'h00000001, 8'h01, 24'h000000, 32'h00000001, 32'h0};
      vecs[1] = '{1'b0, 24'hABCDEF, 32'hDEADBEEF, 8'h01, 24'hABCDEF, 32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b0, 24'hFFFFFF, 32'hFFFFFFFF, 8'h01, 24'hFFFFFF, 32'hFFFFFFFF, 32'h0};
      vecs[3] = '{1'b1, 24'h000002, 32'h00000003, 8'h02, 24'h000002, 32'h0, 32'h00000003};
      vecs[4] = '{1'b1, 24'h123456, 32'hA5C30F81, 8'h02, 24'h123456, 32'h0, 32'hA5C30F81};

      rst_n               = 1'b0;
      bus.spi_rx_valid    = 1'b0;
      bus.spi_rx_byte     = 8'h00;
      bus.value_from_core = 32'h0;
      idle(3);
      check_reset_outputs("reset");
      check("reset_state", {61'h0, bus.dbg_state}, 64'h0);
      rst_n = 1'b1;
      idle(2);

      do_transfer(32'h0, "tx_no_read");

      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({~vecs[i].is_read, vecs[i].exp_instr, vecs[i].exp_addr, vecs[i].exp_val});
         if (vecs[i].is_read) begin
            bus.value_from_core = vecs[i].val;
            do_read(vecs[i].addr);
            bus.value_from_core = 32'h0;
            do_transfer(vecs[i].exp_tx, "vec_tx");
         end else begin
            do_write(vecs[i].addr, vecs[i].val, 1);
         end
      end

      // Burst of three across the address wrap point.
      err_base = err_seen;
      exp_q.push_back({1'b1, 8'h01, 24'hFFFFFF, 32'h11111111});
      exp_q.push_back({1'b1, 8'h01, 24'h000000, 32'h22222222});
      exp_q.push_back({1'b1, 8'h01, 24'h000001, 32'h33333333});
      send_byte(8'h04);
      send_field(32'h00FFFFFF, 3);
      send_byte(8'h03);
      send_field(32'h11111111, 4); idle(1);
      send_field(32'h22222222, 4); idle(1);
      send_field(32'h33333333, 4); idle(1);
      check("burst3_idle", {63'h0, bus.busy}, 64'h0);

      // Count byte 0 means 256 words.
      send_byte(8'h04);
      send_field(32'h00FFFFF0, 3);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         a = 24'hFFFFF0 + 24'(i);
         v = $urandom;
         exp_q.push_back({1'b1, 8'h01, a, v});
         send_field(v, 4);
         if (i == 254) check("burst256_busy", {63'h0, bus.busy}, 64'h1);
         idle(1);
      end
      check("burst256_idle", {63'h0, bus.busy}, 64'h0);
      check("burst_no_err", 64'(err_seen - err_base), 64'h0);

      // Unknown opcode.
      send_byte(8'h7E);
      exp_err++;
      check("badop_err", {63'h0, bus.error}, 64'h1);
      check("badop_state", {61'h0, bus.dbg_state}, 64'h0);
      idle(1);
      check("badop_pulse", {63'h0, bus.error}, 64'h0);

      // Timeout after two address bytes, exact boundary.
      send_byte(8'h01);
      send_field(32'h0, 2);
      idle(TMO - 1);
      check("tmo_early_err", {63'h0, bus.error}, 64'h0);
      check("tmo_early_busy", {63'h0, bus.busy}, 64'h1);
      idle(1);
      exp_err++;
      check("tmo_err", {63'h0, bus.error}, 64'h1);
      check("tmo_busy", {63'h0, bus.busy}, 64'h0);
      idle(2);
      exp_q.push_back({1'b1, 8'h01, 24'h000123, 32'hCAFEF00D});
      do_write(24'h000123, 32'hCAFEF00D, 1);

      // A byte in the would-be timeout cycle wins.
      exp_q.push_back({1'b1, 8'h01, 24'h000077, 32'h12345678});
      send_byte(8'h01);
      idle(TMO - 1);
      send_byte(8'h00);
      check("tmo_precedence", {63'h0, bus.error}, 64'h0);
      send_field(32'h00000077, 2);
      send_field(32'h12345678, 4);
      idle(1);

      // Next opcode lands in the skid during ISSUE.
      exp_q.push_back({1'b1, 8'h01, 24'h000010, 32'h0BADF00D});
      exp_q.push_back({1'b1, 8'h01, 24'h000011, 32'h600DCAFE});
      do_write(24'h000010, 32'h0BADF00D, 0);
      do_write(24'h000011, 32'h600DCAFE, 2);

      // Second byte while the skid is full is dropped with an error.
      bus.value_from_core = 32'h13579BDF;
      exp_q.push_back({1'b0, 8'h02, 24'h000040, 32'h0});
      send_byte(8'h02);
      send_field(32'h00000040, 3);
      send_byte(8'h00);
      send_byte(8'h00);
      exp_err++;
      check("skid_overflow_err", {63'h0, bus.error}, 64'h1);
      idle(2);
      bus.value_from_core = 32'h0;
      do_transfer(32'h13579BDF, "skid_tx");

      // Reset during DATA of a WRITE.
      send_byte(8'h01);
      send_field(32'h00AAAAAA, 3);
      send_field(32'h0000BBBB, 2);
      rst_n = 1'b0;
      idle(2);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      idle(1);
      do_transfer(32'h0, "tx_after_reset");
      exp_q.push_back({1'b1, 8'h01, 24'h000005, 32'h00000006});
      do_write(24'h000005, 32'h00000006, 1);

      idle(5);
      check("pending_strobes", 64'(exp_q.size()), 64'h0);
      check("error_count", 64'(err_seen), 64'(exp_err));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
